// File: rtl/hazard_pkg.sv
// Shared definitions for the hazard/forwarding scoreboard: forwarding select
// encoding, per-stage tag flag layout and the bubble tag flags.
package hazard_pkg;

    localparam logic [1:0] FWD_RF  = 2'd0;
    localparam logic [1:0] FWD_WB  = 2'd1;
    localparam logic [1:0] FWD_MEM = 2'd2;
    localparam logic [1:0] FWD_EX  = 2'd3;

    localparam int FWD_SEL_W = 2;
    localparam int PERF_W    = 32;

    // Register-count independent part of a stage tag; the destination index
    // is appended by the user, whose width depends on NREGS.
    typedef struct packed {
        logic valid;
        logic wr;
        logic load;
    } tag_flags_t;

    localparam int TAG_FLAGS_W = $bits(tag_flags_t);

    // An empty pipeline slot never writes the register file.
    localparam tag_flags_t BUBBLE_FLAGS = '{valid: 1'b0, wr: 1'b0, load: 1'b0};

endpackage

// File: rtl/hazard_scoreboard_if.sv
// Pipeline-side signal bundle of the hazard scoreboard. The master side is the
// processor datapath, the slave side is the scoreboard.
interface hazard_scoreboard_if #(
    parameter int DWIDTH = 16,
    parameter int NREGS  = 8
);
    localparam int RIDX_W = $clog2(NREGS);

    logic              id_valid;
    logic [RIDX_W-1:0] id_rs1;
    logic [RIDX_W-1:0] id_rs2;
    logic              id_rs1_used;
    logic              id_rs2_used;
    logic              id_wr;
    logic [RIDX_W-1:0] id_ws;
    logic              id_is_load;
    logic              flush;
    logic              mem_stall;
    logic [DWIDTH-1:0] rf_rd1;
    logic [DWIDTH-1:0] rf_rd2;
    logic [DWIDTH-1:0] ex_data;
    logic [DWIDTH-1:0] mem_alu_data;
    logic [DWIDTH-1:0] mem_load_data;
    logic [DWIDTH-1:0] wb_data;

    logic [DWIDTH-1:0] op1;
    logic [DWIDTH-1:0] op2;
    logic              stall_id;
    logic              issue;
    logic              hold_ex_mem;
    logic [1:0]        fwd_sel1;
    logic [1:0]        fwd_sel2;
    logic              wb_wr;
    logic [RIDX_W-1:0] wb_ws;
    logic [31:0]       perf_lu_stall;
    logic [31:0]       perf_mem_stall;
    logic [31:0]       perf_fwd;

    modport master (
        output id_valid, id_rs1, id_rs2, id_rs1_used, id_rs2_used, id_wr, id_ws,
               id_is_load, flush, mem_stall, rf_rd1, rf_rd2, ex_data,
               mem_alu_data, mem_load_data, wb_data,
        input  op1, op2, stall_id, issue, hold_ex_mem, fwd_sel1, fwd_sel2,
               wb_wr, wb_ws, perf_lu_stall, perf_mem_stall, perf_fwd
    );

    modport slave (
        input  id_valid, id_rs1, id_rs2, id_rs1_used, id_rs2_used, id_wr, id_ws,
               id_is_load, flush, mem_stall, rf_rd1, rf_rd2, ex_data,
               mem_alu_data, mem_load_data, wb_data,
        output op1, op2, stall_id, issue, hold_ex_mem, fwd_sel1, fwd_sel2,
               wb_wr, wb_ws, perf_lu_stall, perf_mem_stall, perf_fwd
    );

endinterface

// File: rtl/fwd_mux.sv
// Operand forwarding for one ID source: priority match against the EX, MEM and
// WB destination tags, then select the matching data source.
module fwd_mux
    import hazard_pkg::*;
#(
    parameter int DWIDTH = 16,
    parameter int RIDX_W = 3
) (
    input  logic [RIDX_W-1:0] rs,
    input  logic              used,
    input  logic              ex_live,
    input  logic [RIDX_W-1:0] ex_ws,
    input  logic              mem_live,
    input  logic              mem_load,
    input  logic [RIDX_W-1:0] mem_ws,
    input  logic              wb_live,
    input  logic [RIDX_W-1:0] wb_ws,
    input  logic [DWIDTH-1:0] rf_data,
    input  logic [DWIDTH-1:0] ex_data,
    input  logic [DWIDTH-1:0] mem_alu_data,
    input  logic [DWIDTH-1:0] mem_load_data,
    input  logic [DWIDTH-1:0] wb_data,
    output logic [1:0]        sel,
    output logic [DWIDTH-1:0] op
);

    // Youngest matching producer wins; an unread source always reads the RF.
    always_comb begin
        sel = FWD_RF;
        if (used) begin
            if (ex_live && (ex_ws == rs)) begin
                sel = FWD_EX;
            end else if (mem_live && (mem_ws == rs)) begin
                sel = FWD_MEM;
            end else if (wb_live && (wb_ws == rs)) begin
                sel = FWD_WB;
            end
        end
    end

    // Data select; an EX hit on a load returns ex_data, which is never
    // consumed because the load-use interlock holds the instruction.
    always_comb begin
        op = rf_data;
        case (sel)
            FWD_EX:  op = ex_data;
            FWD_MEM: op = mem_load ? mem_load_data : mem_alu_data;
            FWD_WB:  op = wb_data;
            default: op = rf_data;
        endcase
    end

endmodule

// File: rtl/hazard_scoreboard.sv
// Hazard, forwarding and interlock unit for the 5-stage pipeline. Tracks the
// destination tag of the EX/MEM/WB stages, raises load-use and memory-busy
// stalls, inserts bubbles on flush and forwards the ID operands.
// Optional build macro HAZARD_PERF_EN adds saturating performance counters;
// without it the counter outputs are tied to zero.
module hazard_scoreboard
    import hazard_pkg::*;
#(
    parameter int DWIDTH = 16,
    parameter int NREGS  = 8
) (
    input logic                clk,
    input logic                rst,
    hazard_scoreboard_if.slave bus
);

    localparam int RIDX_W = $clog2(NREGS);

    typedef struct packed {
        tag_flags_t        f;
        logic [RIDX_W-1:0] ws;
    } tag_t;

    localparam tag_t BUBBLE_TAG = '{f: BUBBLE_FLAGS, ws: '0};

    tag_t ex_tag;
    tag_t mem_tag;
    tag_t wb_tag;
    tag_t id_tag;

    logic       load_use;
    logic       stall_id;
    logic       issue;
    logic       ex_live;
    logic       mem_live;
    logic       wb_live;
    logic [1:0] sel1;
    logic [1:0] sel2;
    logic       unused_wb_load;

    assign ex_live  = ex_tag.f.valid & ex_tag.f.wr;
    assign mem_live = mem_tag.f.valid & mem_tag.f.wr;
    assign wb_live  = wb_tag.f.valid & wb_tag.f.wr;
    assign unused_wb_load = wb_tag.f.load;

    // Interlock and issue decisions for the instruction sitting in ID.
    always_comb begin
        load_use = ex_live & ex_tag.f.load &
                   ((bus.id_rs1_used & (bus.id_rs1 == ex_tag.ws)) |
                    (bus.id_rs2_used & (bus.id_rs2 == ex_tag.ws)));
        stall_id = load_use | bus.mem_stall;
        issue    = bus.id_valid & ~stall_id & ~bus.flush;
        id_tag   = '{f: '{valid: bus.id_valid, wr: bus.id_wr, load: bus.id_is_load},
                     ws: bus.id_ws};
    end

    // Tag pipeline: a busy memory freezes EX/MEM and drains WB with a bubble
    // so the frozen writeback is not repeated; flush is moot while frozen.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ex_tag  <= BUBBLE_TAG;
            mem_tag <= BUBBLE_TAG;
            wb_tag  <= BUBBLE_TAG;
        end else if (bus.mem_stall) begin
            wb_tag <= BUBBLE_TAG;
        end else begin
            wb_tag  <= mem_tag;
            mem_tag <= ex_tag;
            ex_tag  <= issue ? id_tag : BUBBLE_TAG;
        end
    end

    fwd_mux #(.DWIDTH(DWIDTH), .RIDX_W(RIDX_W)) u_fwd1 (
        .rs(bus.id_rs1), .used(bus.id_rs1_used),
        .ex_live(ex_live), .ex_ws(ex_tag.ws),
        .mem_live(mem_live), .mem_load(mem_tag.f.load), .mem_ws(mem_tag.ws),
        .wb_live(wb_live), .wb_ws(wb_tag.ws),
        .rf_data(bus.rf_rd1), .ex_data(bus.ex_data),
        .mem_alu_data(bus.mem_alu_data), .mem_load_data(bus.mem_load_data),
        .wb_data(bus.wb_data), .sel(sel1), .op(bus.op1)
    );

    fwd_mux #(.DWIDTH(DWIDTH), .RIDX_W(RIDX_W)) u_fwd2 (
        .rs(bus.id_rs2), .used(bus.id_rs2_used),
        .ex_live(ex_live), .ex_ws(ex_tag.ws),
        .mem_live(mem_live), .mem_load(mem_tag.f.load), .mem_ws(mem_tag.ws),
        .wb_live(wb_live), .wb_ws(wb_tag.ws),
        .rf_data(bus.rf_rd2), .ex_data(bus.ex_data),
        .mem_alu_data(bus.mem_alu_data), .mem_load_data(bus.mem_load_data),
        .wb_data(bus.wb_data), .sel(sel2), .op(bus.op2)
    );

    assign bus.stall_id    = stall_id;
    assign bus.issue       = issue;
    assign bus.hold_ex_mem = bus.mem_stall;
    assign bus.fwd_sel1    = sel1;
    assign bus.fwd_sel2    = sel2;
    assign bus.wb_wr       = wb_live;
    assign bus.wb_ws       = wb_tag.ws;

`ifdef HAZARD_PERF_EN
    logic [PERF_W-1:0] perf_lu_q;
    logic [PERF_W-1:0] perf_mem_q;
    logic [PERF_W-1:0] perf_fwd_q;

    // Event counters that stick at all-ones instead of wrapping.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_lu_q  <= '0;
            perf_mem_q <= '0;
            perf_fwd_q <= '0;
        end else begin
            if (load_use && !bus.mem_stall && (perf_lu_q != '1)) begin
                perf_lu_q <= perf_lu_q + 1'b1;
            end
            if (bus.mem_stall && (perf_mem_q != '1)) begin
                perf_mem_q <= perf_mem_q + 1'b1;
            end
            if (issue && ((sel1 != FWD_RF) || (sel2 != FWD_RF)) && (perf_fwd_q != '1)) begin
                perf_fwd_q <= perf_fwd_q + 1'b1;
            end
        end
    end

    assign bus.perf_lu_stall  = perf_lu_q;
    assign bus.perf_mem_stall = perf_mem_q;
    assign bus.perf_fwd       = perf_fwd_q;
`else
    assign bus.perf_lu_stall  = '0;
    assign bus.perf_mem_stall = '0;
    assign bus.perf_fwd       = '0;
`endif

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Self-checking bench for hazard_scoreboard: a 16-bit/8-register instance for
// the main scenarios and a 32-bit/16-register instance for the wide case.
module tb_hazard_scoreboard;
    import hazard_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    hazard_scoreboard_if #(.DWIDTH(16), .NREGS(8))  bus0 ();
    hazard_scoreboard_if #(.DWIDTH(32), .NREGS(16)) bus1 ();

    hazard_scoreboard #(.DWIDTH(16), .NREGS(8))  dut0 (.clk(clk), .rst(rst), .bus(bus0));
    hazard_scoreboard #(.DWIDTH(32), .NREGS(16)) dut1 (.clk(clk), .rst(rst), .bus(bus1));

`ifdef HAZARD_PERF_EN
    localparam logic PERF = 1'b1;
`else
    localparam logic PERF = 1'b0;
`endif

    localparam int F_STALL = 0, F_ISSUE = 1, F_HOLD = 2, F_SEL1 = 3, F_SEL2 = 4,
                   F_OP1 = 5, F_OP2 = 6, F_WBWR = 7, F_WBWS = 8, F_PLU = 9,
                   F_PMS = 10, F_PFWD = 11;
    string fname [12] = '{"stall_id", "issue", "hold_ex_mem", "fwd_sel1", "fwd_sel2",
                          "op1", "op2", "wb_wr", "wb_ws", "perf_lu_stall",
                          "perf_mem_stall", "perf_fwd"};

    typedef struct {
        int          cyc;
        int          dut;
        int          fld;
        logic [31:0] v;
    } exp_t;

    typedef struct {
        logic valid;
        int   rs1;
        logic u1;
        int   rs2;
        logic u2;
        logic wr;
        int   ws;
        logic ld;
        logic fl;
        logic ms;
    } stim_t;

    exp_t  exp_q [$];
    int    n_total = 0;
    int    n_pass  = 0;

    function automatic void want(int c, int d, int f, logic [31:0] v);
        exp_t e;
        e.cyc = c; e.dut = d; e.fld = f; e.v = v;
        exp_q.push_back(e);
    endfunction

    function automatic stim_t st(logic valid, int rs1, logic u1, int rs2, logic u2,
                                 logic wr, int ws, logic ld, logic fl, logic ms);
        stim_t s;
        s.valid = valid; s.rs1 = rs1; s.u1 = u1; s.rs2 = rs2; s.u2 = u2;
        s.wr = wr; s.ws = ws; s.ld = ld; s.fl = fl; s.ms = ms;
        return s;
    endfunction

    function automatic stim_t idle();
        return st(1'b0, 0, 1'b0, 0, 1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b0);
    endfunction

    function automatic logic [31:0] act(int d, int f);
        logic [31:0] r;
        r = '0;
        if (d == 0) begin
            case (f)
                F_STALL: r = 32'(bus0.stall_id);
                F_ISSUE: r = 32'(bus0.issue);
                F_HOLD:  r = 32'(bus0.hold_ex_mem);
                F_SEL1:  r = 32'(bus0.fwd_sel1);
                F_SEL2:  r = 32'(bus0.fwd_sel2);
                F_OP1:   r = 32'(bus0.op1);
                F_OP2:   r = 32'(bus0.op2);
                F_WBWR:  r = 32'(bus0.wb_wr);
                F_WBWS:  r = 32'(bus0.wb_ws);
                F_PLU:   r = bus0.perf_lu_stall;
                F_PMS:   r = bus0.perf_mem_stall;
                default: r = bus0.perf_fwd;
            endcase
        end else begin
            case (f)
                F_STALL: r = 32'(bus1.stall_id);
                F_ISSUE: r = 32'(bus1.issue);
                F_HOLD:  r = 32'(bus1.hold_ex_mem);
                F_SEL1:  r = 32'(bus1.fwd_sel1);
                F_SEL2:  r = 32'(bus1.fwd_sel2);
                F_OP1:   r = bus1.op1;
                F_OP2:   r = bus1.op2;
                F_WBWR:  r = 32'(bus1.wb_wr);
                F_WBWS:  r = 32'(bus1.wb_ws);
                F_PLU:   r = bus1.perf_lu_stall;
                F_PMS:   r = bus1.perf_mem_stall;
                default: r = bus1.perf_fwd;
            endcase
        end
        return r;
    endfunction

    task automatic drive(input int d, input stim_t s);
        if (d == 0) begin
            bus0.id_valid = s.valid;     bus0.id_rs1 = 3'(s.rs1);
            bus0.id_rs1_used = s.u1;     bus0.id_rs2 = 3'(s.rs2);
            bus0.id_rs2_used = s.u2;     bus0.id_wr = s.wr;
            bus0.id_ws = 3'(s.ws);       bus0.id_is_load = s.ld;
            bus0.flush = s.fl;           bus0.mem_stall = s.ms;
        end else begin
            bus1.id_valid = s.valid;     bus1.id_rs1 = 4'(s.rs1);
            bus1.id_rs1_used = s.u1;     bus1.id_rs2 = 4'(s.rs2);
            bus1.id_rs2_used = s.u2;     bus1.id_wr = s.wr;
            bus1.id_ws = 4'(s.ws);       bus1.id_is_load = s.ld;
            bus1.flush = s.fl;           bus1.mem_stall = s.ms;
        end
    endtask

    task automatic drain(input int n);
        drive(0, idle());
        drive(1, idle());
        repeat (n) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset();
        stim_t s [$];
        exp_t e;
        logic [31:0] a;
        s.push_back(st(1'b0, 0, 1'b1, 0, 1'b1, 1'b0, 0, 1'b0, 1'b0, 1'b0));
        for (int d = 0; d < 2; d++) begin
            want(0, d, F_STALL, 0); want(0, d, F_ISSUE, 0); want(0, d, F_WBWR, 0);
            want(0, d, F_WBWS, 0);  want(0, d, F_SEL1, 0);  want(0, d, F_SEL2, 0);
            want(0, d, F_PLU, 0);   want(0, d, F_PMS, 0);   want(0, d, F_PFWD, 0);
        end
        for (int c = 0; c < s.size(); c++) begin
            drive(0, s[c]); drive(1, s[c]);
            @(negedge clk);
            while (exp_q.size() > 0 && exp_q[0].cyc == c) begin
                e = exp_q.pop_front(); a = act(e.dut, e.fld); n_total++;
                if (a !== e.v) $display("FAIL reset.%s dut%0d: got %0h want %0h", fname[e.fld], e.dut, a, e.v);
                else n_pass++;
            end
            @(posedge clk); #1;
        end
        rst = 1'b0;
        drain(1);
    endtask

    task automatic test_forward_ex();
        stim_t s [$];
        exp_t e;
        logic [31:0] a;
        bus0.ex_data = 16'h0005; bus0.rf_rd1 = 16'h1111; bus0.rf_rd2 = 16'h2222;
        s.push_back(st(1'b1, 0, 1'b0, 0, 1'b0, 1'b1, 1, 1'b0, 1'b0, 1'b0));
        want(0, 0, F_ISSUE, 1);
        s.push_back(st(1'b1, 1, 1'b1, 0, 1'b0, 1'b1, 5, 1'b0, 1'b0, 1'b0));
        want(1, 0, F_SEL1, 3); want(1, 0, F_OP1, 32'h0005);
        want(1, 0, F_STALL, 0); want(1, 0, F_ISSUE, 1);
        s.push_back(idle());
        want(2, 0, F_WBWR, 0);
        s.push_back(idle());
        want(3, 0, F_WBWR, 1); want(3, 0, F_WBWS, 1);
        for (int c = 0; c < s.size(); c++) begin
            drive(0, s[c]);
            @(negedge clk);
            while (exp_q.size() > 0 && exp_q[0].cyc == c) begin
                e = exp_q.pop_front(); a = act(e.dut, e.fld); n_total++;
                if (a !== e.v) $display("FAIL fwd_ex.%s cyc%0d: got %0h want %0h", fname[e.fld], c, a, e.v);
                else n_pass++;
            end
            @(posedge clk); #1;
        end
        drain(3);
    endtask

    task automatic test_load_use();
        stim_t s [$];
        exp_t e;
        logic [31:0] a;
        bus0.mem_alu_data = 16'h1234; bus0.mem_load_data = 16'hBEEF;
        s.push_back(st(1'b1, 0, 1'b0, 0, 1'b0, 1'b1, 2, 1'b1, 1'b0, 1'b0));
        want(0, 0, F_ISSUE, 1);
        s.push_back(st(1'b1, 0, 1'b0, 2, 1'b1, 1'b1, 6, 1'b0, 1'b0, 1'b0));
        want(1, 0, F_STALL, 1); want(1, 0, F_ISSUE, 0); want(1, 0, F_HOLD, 0);
        s.push_back(st(1'b1, 0, 1'b0, 2, 1'b1, 1'b1, 6, 1'b0, 1'b0, 1'b0));
        want(2, 0, F_STALL, 0); want(2, 0, F_ISSUE, 1); want(2, 0, F_SEL2, 2);
        want(2, 0, F_OP2, 32'hBEEF); want(2, 0, F_SEL1, 0);
        for (int c = 0; c < s.size(); c++) begin
            drive(0, s[c]);
            @(negedge clk);
            while (exp_q.size() > 0 && exp_q[0].cyc == c) begin
                e = exp_q.pop_front(); a = act(e.dut, e.fld); n_total++;
                if (a !== e.v) $display("FAIL load_use.%s cyc%0d: got %0h want %0h", fname[e.fld], c, a, e.v);
                else n_pass++;
            end
            @(posedge clk); #1;
        end
        drain(3);
    endtask

    task automatic test_priority();
        stim_t s [$];
        exp_t e;
        logic [31:0] a;
        bus0.ex_data = 16'h0011; bus0.wb_data = 16'h0022;
        bus0.mem_alu_data = 16'h0033; bus0.mem_load_data = 16'h0044;
        s.push_back(st(1'b1, 0, 1'b0, 0, 1'b0, 1'b1, 3, 1'b0, 1'b0, 1'b0));
        s.push_back(st(1'b1, 0, 1'b0, 0, 1'b0, 1'b1, 7, 1'b0, 1'b0, 1'b0));
        s.push_back(st(1'b1, 0, 1'b0, 0, 1'b0, 1'b1, 3, 1'b0, 1'b0, 1'b0));
        s.push_back(st(1'b0, 3, 1'b1, 7, 1'b1, 1'b0, 0, 1'b0, 1'b0, 1'b0));
        want(3, 0, F_SEL1, 3); want(3, 0, F_OP1, 32'h0011); want(3, 0, F_STALL, 0);
        want(3, 0, F_SEL2, 2); want(3, 0, F_OP2, 32'h0033);
        s.push_back(st(1'b0, 3, 1'b1, 7, 1'b1, 1'b0, 0, 1'b0, 1'b0, 1'b0));
        want(4, 0, F_SEL1, 2); want(4, 0, F_OP1, 32'h0033);
        want(4, 0, F_SEL2, 1); want(4, 0, F_OP2, 32'h0022);
        s.push_back(st(1'b0, 3, 1'b0, 3, 1'b1, 1'b0, 0, 1'b0, 1'b0, 1'b0));
        want(5, 0, F_SEL1, 0); want(5, 0, F_OP1, 32'h1111);
        want(5, 0, F_SEL2, 1); want(5, 0, F_OP2, 32'h0022);
        for (int c = 0; c < s.size(); c++) begin
            drive(0, s[c]);
            @(negedge clk);
            while (exp_q.size() > 0 && exp_q[0].cyc == c) begin
                e = exp_q.pop_front(); a = act(e.dut, e.fld); n_total++;
                if (a !== e.v) $display("FAIL priority.%s cyc%0d: got %0h want %0h", fname[e.fld], c, a, e.v);
                else n_pass++;
            end
            @(posedge clk); #1;
        end
        drain(3);
    endtask

    task automatic test_mem_stall();
        stim_t s [$];
        exp_t e;
        logic [31:0] a;
        s.push_back(st(1'b1, 0, 1'b0, 0, 1'b0, 1'b1, 4, 1'b0, 1'b0, 1'b0));
        s.push_back(st(1'b1, 0, 1'b0, 0, 1'b0, 1'b1, 5, 1'b0, 1'b0, 1'b0));
        for (int c = 2; c < 5; c++) begin
            s.push_back(st(1'b1, 4, 1'b1, 5, 1'b1, 1'b1, 7, 1'b0, 1'b0, 1'b1));
            want(c, 0, F_STALL, 1); want(c, 0, F_ISSUE, 0); want(c, 0, F_HOLD, 1);
            want(c, 0, F_WBWR, 0);  want(c, 0, F_SEL1, 2);  want(c, 0, F_SEL2, 3);
        end
        s.push_back(st(1'b0, 4, 1'b1, 5, 1'b1, 1'b0, 0, 1'b0, 1'b0, 1'b0));
        want(5, 0, F_HOLD, 0); want(5, 0, F_WBWR, 0);
        want(5, 0, F_SEL1, 2); want(5, 0, F_SEL2, 3);
        s.push_back(idle());
        want(6, 0, F_WBWR, 1); want(6, 0, F_WBWS, 4);
        s.push_back(idle());
        want(7, 0, F_WBWR, 1); want(7, 0, F_WBWS, 5);
        s.push_back(idle());
        want(8, 0, F_WBWR, 0);
        for (int c = 0; c < s.size(); c++) begin
            drive(0, s[c]);
            @(negedge clk);
            while (exp_q.size() > 0 && exp_q[0].cyc == c) begin
                e = exp_q.pop_front(); a = act(e.dut, e.fld); n_total++;
                if (a !== e.v) $display("FAIL mem_stall.%s cyc%0d: got %0h want %0h", fname[e.fld], c, a, e.v);
                else n_pass++;
            end
            @(posedge clk); #1;
        end
        drain(3);
    endtask

    task automatic test_flush();
        stim_t s [$];
        exp_t e;
        logic [31:0] a;
        s.push_back(st(1'b1, 0, 1'b0, 0, 1'b0, 1'b1, 6, 1'b0, 1'b1, 1'b0));
        want(0, 0, F_ISSUE, 0); want(0, 0, F_STALL, 0);
        s.push_back(st(1'b0, 6, 1'b1, 0, 1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b0));
        want(1, 0, F_SEL1, 0);
        s.push_back(st(1'b1, 0, 1'b0, 0, 1'b0, 1'b1, 2, 1'b0, 1'b0, 1'b0));
        want(2, 0, F_ISSUE, 1);
        s.push_back(st(1'b1, 0, 1'b0, 0, 1'b0, 1'b1, 3, 1'b0, 1'b1, 1'b1));
        want(3, 0, F_ISSUE, 0); want(3, 0, F_STALL, 1);
        s.push_back(st(1'b0, 2, 1'b1, 0, 1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b0));
        want(4, 0, F_SEL1, 3);
        s.push_back(st(1'b0, 2, 1'b1, 3, 1'b1, 1'b0, 0, 1'b0, 1'b0, 1'b0));
        want(5, 0, F_SEL1, 2); want(5, 0, F_SEL2, 0);
        for (int c = 0; c < s.size(); c++) begin
            drive(0, s[c]);
            @(negedge clk);
            while (exp_q.size() > 0 && exp_q[0].cyc == c) begin
                e = exp_q.pop_front(); a = act(e.dut, e.fld); n_total++;
                if (a !== e.v) $display("FAIL flush.%s cyc%0d: got %0h want %0h", fname[e.fld], c, a, e.v);
                else n_pass++;
            end
            @(posedge clk); #1;
        end
        drain(3);
    endtask

    task automatic test_wide();
        stim_t s [$];
        exp_t e;
        logic [31:0] a;
        bus1.mem_alu_data = 32'hCAFEF00D; bus1.mem_load_data = 32'h12345678;
        bus1.ex_data = 32'h0BADBEEF;      bus1.wb_data = 32'h55AA55AA;
        s.push_back(st(1'b1, 0, 1'b0, 0, 1'b0, 1'b1, 15, 1'b0, 1'b0, 1'b0));
        want(0, 1, F_ISSUE, 1);
        s.push_back(idle());
        s.push_back(st(1'b1, 15, 1'b1, 0, 1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b0));
        want(2, 1, F_SEL1, 2); want(2, 1, F_OP1, 32'hCAFEF00D); want(2, 1, F_ISSUE, 1);
        want(2, 1, F_PFWD, 0);
        s.push_back(idle());
        want(3, 1, F_PFWD, PERF ? 32'd1 : 32'd0);
        for (int c = 0; c < s.size(); c++) begin
            drive(1, s[c]);
            @(negedge clk);
            while (exp_q.size() > 0 && exp_q[0].cyc == c) begin
                e = exp_q.pop_front(); a = act(e.dut, e.fld); n_total++;
                if (a !== e.v) $display("FAIL wide.%s cyc%0d: got %0h want %0h", fname[e.fld], c, a, e.v);
                else n_pass++;
            end
            @(posedge clk); #1;
        end
        drain(3);
    endtask

    task automatic test_perf();
        exp_t e;
        logic [31:0] a;
        drive(0, idle());
        want(0, 0, F_PLU, PERF ? 32'd1 : 32'd0);
        want(0, 0, F_PMS, PERF ? 32'd4 : 32'd0);
        want(0, 0, F_PFWD, PERF ? 32'd2 : 32'd0);
        want(0, 1, F_PFWD, PERF ? 32'd1 : 32'd0);
        @(negedge clk);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); a = act(e.dut, e.fld); n_total++;
            if (a !== e.v) $display("FAIL perf.%s dut%0d: got %0h want %0h", fname[e.fld], e.dut, a, e.v);
            else n_pass++;
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid();
        exp_t e;
        logic [31:0] a;
        bus0.rf_rd1 = 16'h1111;
        drive(0, st(1'b1, 0, 1'b0, 0, 1'b0, 1'b1, 3, 1'b0, 1'b0, 1'b0));
        @(posedge clk); #1;
        drive(0, st(1'b0, 3, 1'b1, 0, 1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b1));
        want(0, 0, F_SEL1, 3);
        want(1, 0, F_SEL1, 0); want(1, 0, F_OP1, 32'h1111); want(1, 0, F_PMS, 0);
        want(2, 0, F_SEL1, 0); want(2, 0, F_WBWR, 0);
        for (int c = 0; c < 3; c++) begin
            if (c == 0) begin
                @(negedge clk);
            end else if (c == 1) begin
                #1 rst = 1'b1;
                #1;
            end else begin
                @(posedge clk); #1;
                rst = 1'b0;
                bus0.mem_stall = 1'b0;
                @(negedge clk);
            end
            while (exp_q.size() > 0 && exp_q[0].cyc == c) begin
                e = exp_q.pop_front(); a = act(e.dut, e.fld); n_total++;
                if (a !== e.v) $display("FAIL reset_mid.%s step%0d: got %0h want %0h", fname[e.fld], c, a, e.v);
                else n_pass++;
            end
        end
        drain(1);
    endtask

    initial begin
        bus0.rf_rd1 = 16'h1111; bus0.rf_rd2 = 16'h2222; bus0.ex_data = '0;
        bus0.mem_alu_data = '0; bus0.mem_load_data = '0; bus0.wb_data = '0;
        bus1.rf_rd1 = 32'h11111111; bus1.rf_rd2 = 32'h22222222; bus1.ex_data = '0;
        bus1.mem_alu_data = '0; bus1.mem_load_data = '0; bus1.wb_data = '0;
        drive(0, idle());
        drive(1, idle());
        @(posedge clk); #1;
        test_reset();
        test_forward_ex();
        test_load_use();
        test_priority();
        test_mem_stall();
        test_flush();
        test_wide();
        test_perf();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed", n_pass, n_total);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/hazard_scoreboard.md
Name: hazard_scoreboard

Overview:
Parametrised hazard, forwarding and interlock unit for the 5-stage pipeline. It owns a tag pipeline mirroring EX/MEM/WB destination info. It issues load-use and memory-busy stalls, handles branch flush bubbles, and delivers forwarded ID operands. It replaces ad-hoc stall/forward equations in the processor top with one reusable, width- and register-count-generic block.

Parameters:
DWIDTH, 16, datapath width of operands and forwarded values
NREGS, 8, architectural register count
RIDX_W, $clog2(NREGS), register index width (derived; never overridden)

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
id_valid  in  1  ID holds a real instruction
id_rs1 / id_rs2  in  RIDX_W  source register indices
id_rs1_used / id_rs2_used  in  1  source actually read by the instruction
id_wr  in  1  ID instruction writes RF
id_ws  in  RIDX_W  ID destination index
id_is_load  in  1  ID instruction is a load
flush  in  1  branch/jump taken in EX; kill ID instruction
mem_stall  in  1  data memory busy (Stall | !Done)
rf_rd1 / rf_rd2  in  DWIDTH  RF read data
ex_data / mem_alu_data / mem_load_data / wb_data  in  DWIDTH  forwarding sources
op1 / op2  out  DWIDTH  forwarded ID operands
stall_id  out  1  hold PC and IF/ID
issue  out  1  ID instruction advances into EX this cycle
hold_ex_mem  out  1  freeze ID/EX and EX/MEM registers (= mem_stall)
fwd_sel1 / fwd_sel2  out  2  selected source per operand
wb_wr  out  1  RF write enable for WB
wb_ws  out  RIDX_W  RF write index for WB

Behaviour:
- Tag per stage (EX, MEM, WB): {valid, wr, ws, load}. Reset clears all tags: valid=0, wr=0, ws=0, load=0. Outputs at reset: stall_id=0, issue=0, wb_wr=0, wb_ws=0, fwd_sel=RF.
- load_use = EX.valid & EX.wr & EX.load & ((id_rs1_used & id_rs1==EX.ws) | (id_rs2_used & id_rs2==EX.ws)).
- stall_id = load_use | mem_stall (combinational).
- issue = id_valid & !stall_id & !flush.
- Tag update on the clock edge:
  - If mem_stall: EX and MEM hold. WB takes a bubble (valid=0), so a frozen writeback is never re-written.
  - Else: WB<=MEM, MEM<=EX. EX<=ID tag if issue, otherwise a bubble.
- flush during mem_stall is ignored. EX is frozen, so the branch is re-presented the following cycle.
- A bubble tag always has wr=0.
- Forwarding per operand: priority EX > MEM > WB > RF. Match requires stage valid & wr & ws==rs.
  - EX match with EX.load yields a don't-care value; load_use stalls the operand anyway.
  - MEM match selects mem_load_data if MEM.load, else mem_alu_data.
  - Unused source (rsN_used=0): fwd_sel=RF.
- fwd_sel encoding: 0 RF, 1 WB, 2 MEM, 3 EX. op mux is combinational, zero latency.
- wb_wr = WB.valid & WB.wr. wb_ws = WB.ws.
- Reset asserted mid-stall clears tags immediately; the first cycle after reset has no forwarding.

Optional Feature:
HAZARD_PERF_EN
- Defined: adds 32-bit saturating counters (reset 0) on outputs perf_lu_stall, perf_mem_stall, perf_fwd.
  - perf_lu_stall counts cycles with load_use & !mem_stall.
  - perf_mem_stall counts cycles with mem_stall.
  - perf_fwd counts cycles with issue where either fwd_sel != RF.
  - Counters hold at 32'hFFFFFFFF.
- Undefined: the counter ports remain and are tied to 0. No counter flops are generated.

Decomposition:
- hazard_pkg holds:
  - fwd_sel localparams FWD_RF/FWD_WB/FWD_MEM/FWD_EX.
  - stage tag struct/field widths.
  - Bubble tag constant.
- One sub-module, fwd_mux: priority compare against three tags plus the data select. Instantiated once per operand.

Test Plan:
- Reset then ADD r1 issued, SUB reading r1 next cycle with ex_data=16'h0005 -> fwd_sel1=3, op1=16'h0005, stall_id=0.
- LD r2 in EX, consumer reads r2 (rs2_used=1) -> stall_id=1, issue=0 for 1 cycle. Next cycle fwd_sel2=2, op2=mem_load_data=16'hBEEF.
- Same index r3 written by EX and WB, rs1=r3 -> EX wins: op1=ex_data=16'h0011, not wb_data=16'h0022.
- mem_stall held 3 cycles with MEM tag r4 -> EX/MEM tags unchanged, wb_wr=0 all 3 cycles. On release, WB=r4 and wb_wr=1 exactly once.
- flush with id_valid=1 -> issue=0, next EX tag bubble (wr=0). flush with mem_stall=1 -> EX tag unchanged.
- NREGS=16, DWIDTH=32: rs1=4'd15 matches MEM ws=15 non-load -> op1=mem_alu_data=32'hCAFEF00D. With HAZARD_PERF_EN defined, perf_fwd increments by 1.
